// File: rtl/javk_alu_ctrl.sv
// JAVK execution/control core: instruction decoder, 8-bit ALU and flag register.
// Latency: decode strobes are combinational (0 cycles); alu_out/flags/alu_clk register 1 cycle after an ALU instruction.
// Backpressure: none; one instruction is consumed per clock from instr, and the CPU top sequences the instruction stream.
module javk_alu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] alu_out,
    output logic       alu_clk,
    output logic [3:0] flags,
    output logic [2:0] alu_op,
    output logic [3:0] alu_shamt,
    output logic [3:0] reg_sel,
    output logic       nibble_read,
    output logic       nibble_hl,
    output logic [3:0] nibble_out,
    output logic       mva,
    output logic       fetch,
    output logic       we,
    output logic [3:0] addr_offset,
    output logic       mvb,
    output logic [1:0] reg16_dst,
    output logic [1:0] reg16_src,
    output logic       jmp,
    output logic       jpl,
    output logic       branch
);

    // ALU operation codes (instr[6:4] of a 0ooo rrrr instruction)
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // Flag bit positions inside {V,N,C,Z}
    localparam int FL_Z = 0;
    localparam int FL_C = 1;
    localparam int FL_N = 2;
    localparam int FL_V = 3;

    // Upper-nibble instruction groups for the non-ALU half of the opcode map
    localparam logic [3:0] GRP_NIB_L = 4'h8;
    localparam logic [3:0] GRP_NIB_H = 4'h9;
    localparam logic [3:0] GRP_MVA   = 4'hA;
    localparam logic [3:0] GRP_LOAD  = 4'hB;
    localparam logic [3:0] GRP_STORE = 4'hC;
    localparam logic [3:0] GRP_MVB   = 4'hD;
    localparam logic [3:0] GRP_JMP   = 4'hE;
    localparam logic [3:0] GRP_JPL   = 4'hF;

    logic [7:0] r_alu_out;
    logic [3:0] r_flags;
    logic       r_alu_clk;

    logic       w_is_alu;
    logic       w_alu_wr;
    logic       w_alu_cmp;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [8:0] w_shl;
    logic [8:0] w_shr;
    logic [7:0] w_result;
    logic       w_c;
    logic       w_v;
    logic [3:0] w_new_flags;
    logic       w_cond;

    // Bit fields are passed through unconditionally; consumers qualify them with the strobes.
    assign alu_op      = instr[6:4];
    assign alu_shamt   = instr[3:0];
    assign reg_sel     = instr[3:0];
    assign nibble_out  = instr[3:0];
    assign addr_offset = instr[3:0];
    assign reg16_dst   = instr[3:2];
    assign reg16_src   = instr[1:0];

    assign w_is_alu  = ~instr[7];
    assign w_alu_wr  = w_is_alu && (alu_op != OP_CMP);
    assign w_alu_cmp = w_is_alu && (alu_op == OP_CMP);

    // Decode the instruction group into one-hot datapath strobes; reset silences them all.
    always_comb begin
        nibble_read = 1'b0;
        nibble_hl   = 1'b0;
        mva         = 1'b0;
        fetch       = 1'b0;
        we          = 1'b0;
        mvb         = 1'b0;
        jmp         = 1'b0;
        jpl         = 1'b0;
        if (!rst) begin
            case (instr[7:4])
                GRP_NIB_L, GRP_NIB_H: begin
                    nibble_read = 1'b1;
                    nibble_hl   = instr[4];
                end
                GRP_MVA:   mva = 1'b1;
                GRP_LOAD:  fetch = 1'b1;
                GRP_STORE: begin
                    fetch = 1'b1;
                    we    = 1'b1;
                end
                GRP_MVB:   mvb = 1'b1;
                GRP_JMP:   jmp = 1'b1;
                GRP_JPL:   jpl = 1'b1;
                default: ;
            endcase
        end
    end

    // Evaluate the jump condition code against the registered flags.
    always_comb begin
        w_cond = 1'b0;
        case (instr[3:0])
            4'd0:    w_cond = 1'b1;
            4'd1:    w_cond = r_flags[FL_Z];
            4'd2:    w_cond = ~r_flags[FL_Z];
            4'd3:    w_cond = r_flags[FL_C];
            4'd4:    w_cond = ~r_flags[FL_C];
            4'd5:    w_cond = r_flags[FL_N];
            4'd6:    w_cond = ~r_flags[FL_N];
            4'd7:    w_cond = r_flags[FL_V];
            4'd8:    w_cond = ~r_flags[FL_V];
            default: w_cond = 1'b0;
        endcase
    end

    // jmp/jpl are already zero in reset and for non-jump instructions.
    assign branch = (jmp | jpl) & w_cond;

    // Nine-bit datapaths: bit 8 of add/sub is carry/borrow. For the shifts the
    // extra bit catches the last bit shifted out; shifting by 9..15 empties both
    // the result and that bit, which gives result=0, C=0 without special casing.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_shl  = {1'b0, a} << alu_shamt;
    assign w_shr  = {a, 1'b0} >> alu_shamt;

    // Select the ALU result plus carry and overflow for the decoded operation.
    always_comb begin
        w_result = 8'h00;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (alu_op)
            OP_ADD: begin
                w_result = w_sum[7:0];
                w_c      = w_sum[8];
                w_v      = (a[7] == b[7]) && (w_sum[7] != a[7]);
            end
            OP_SUB, OP_CMP: begin
                w_result = w_diff[7:0];
                w_c      = w_diff[8];
                w_v      = (a[7] != b[7]) && (w_diff[7] != a[7]);
            end
            OP_AND: w_result = a & b;
            OP_OR:  w_result = a | b;
            OP_XOR: w_result = a ^ b;
            OP_SHL: begin
                w_result = w_shl[7:0];
                w_c      = w_shl[8];
            end
            OP_SHR: begin
                w_result = w_shr[8:1];
                w_c      = w_shr[0];
            end
            default: ;
        endcase
    end

    assign w_new_flags = {w_v, w_result[7], w_c, (w_result == 8'h00)};

    // Register the ALU result and flags; CMP only touches flags and never pulses alu_clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= 8'h00;
            r_flags   <= 4'h0;
            r_alu_clk <= 1'b0;
        end else if (w_alu_wr) begin
            r_alu_out <= w_result;
            r_flags   <= w_new_flags;
            r_alu_clk <= 1'b1;
        end else if (w_alu_cmp) begin
            r_flags   <= w_new_flags;
            r_alu_clk <= 1'b0;
        end else begin
            r_alu_clk <= 1'b0;
        end
    end

    assign alu_out = r_alu_out;
    assign flags   = r_flags;
    assign alu_clk = r_alu_clk;

endmodule

// File: tb/tb_javk_alu_ctrl.sv
// Bench for javk_alu_ctrl: scoreboarded ALU results plus decode/branch checks.
// Latency: ALU expectations popped one clock after being driven.
// Backpressure: none; stimulus is applied once per clock.
module tb_javk_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] alu_out;
    logic       alu_clk;
    logic [3:0] flags;
    logic [2:0] alu_op;
    logic [3:0] alu_shamt;
    logic [3:0] reg_sel;
    logic       nibble_read;
    logic       nibble_hl;
    logic [3:0] nibble_out;
    logic       mva;
    logic       fetch;
    logic       we;
    logic [3:0] addr_offset;
    logic       mvb;
    logic [1:0] reg16_dst;
    logic [1:0] reg16_src;
    logic       jmp;
    logic       jpl;
    logic       branch;

    javk_alu_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .a(a), .b(b),
        .alu_out(alu_out), .alu_clk(alu_clk), .flags(flags),
        .alu_op(alu_op), .alu_shamt(alu_shamt), .reg_sel(reg_sel),
        .nibble_read(nibble_read), .nibble_hl(nibble_hl), .nibble_out(nibble_out),
        .mva(mva), .fetch(fetch), .we(we), .addr_offset(addr_offset),
        .mvb(mvb), .reg16_dst(reg16_dst), .reg16_src(reg16_src),
        .jmp(jmp), .jpl(jpl), .branch(branch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out;
        logic [3:0] fl;
        logic       pulse;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_out;
    logic [3:0] m_fl;
    int         total;
    int         bad;

    // Reference ALU: integer arithmetic and bit-at-a-time shifts; returns {V,N,C,Z,result}.
    function automatic logic [11:0] model_alu(input logic [2:0] op, input logic [7:0] x,
                                              input logic [7:0] y, input logic [3:0] s);
        logic [7:0] r;
        logic       c;
        logic       v;
        int         u;
        int         sv;
        r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                u  = int'(x) + int'(y);
                sv = int'($signed(x)) + int'($signed(y));
                r  = u[7:0];
                c  = (u > 255);
                v  = (sv > 127) || (sv < -128);
            end
            3'd1, 3'd7: begin
                u  = int'(x) - int'(y);
                sv = int'($signed(x)) - int'($signed(y));
                r  = u[7:0];
                c  = (x < y);
                v  = (sv > 127) || (sv < -128);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin
                r = x;
                for (int i = 0; i < int'(s); i++) begin
                    c = r[7];
                    r = {r[6:0], 1'b0};
                end
            end
            default: begin
                r = x;
                for (int i = 0; i < int'(s); i++) begin
                    c = r[0];
                    r = {1'b0, r[7:1]};
                end
            end
        endcase
        return {v, r[7], c, (r == 8'h00), r};
    endfunction

    function automatic logic exp_branch(input logic [3:0] cc, input logic [3:0] fl);
        case (cc)
            4'd0: return 1'b1;
            4'd1: return fl[0];
            4'd2: return ~fl[0];
            4'd3: return fl[1];
            4'd4: return ~fl[1];
            4'd5: return fl[2];
            4'd6: return ~fl[2];
            4'd7: return fl[3];
            4'd8: return ~fl[3];
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction at the falling edge and push the registered outcome expected after the next rising edge.
    task automatic push_alu(input logic [7:0] ins, input logic [7:0] x, input logic [7:0] y, input logic r);
        logic [11:0] res;
        exp_t        e;
        @(negedge clk);
        rst = r; instr = ins; a = x; b = y;
        e.pulse = 1'b0;
        if (r) begin
            m_out = 8'h00;
            m_fl  = 4'h0;
        end else if (!ins[7]) begin
            res  = model_alu(ins[6:4], x, y, ins[3:0]);
            m_fl = res[11:8];
            if (ins[6:4] != 3'd7) begin
                m_out   = res[7:0];
                e.pulse = 1'b1;
            end
        end
        e.out = m_out;
        e.fl  = m_fl;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        push_alu(8'hE0, 8'h00, 8'h00, 1'b1);
        #1;
        total++;
        if ({nibble_read, nibble_hl, mva, fetch, we, mvb, jmp, jpl, branch} !== 9'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want %b", {nibble_read, nibble_hl, mva, fetch, we, mvb, jmp, jpl, branch}, 9'b0);
        end
        total++;
        if ({alu_op, alu_shamt, reg16_dst, reg16_src} !== {3'd6, 4'h0, 2'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_fields: got %h want %h", {alu_op, alu_shamt, reg16_dst, reg16_src}, {3'd6, 4'h0, 2'd0, 2'd0});
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if ({alu_out, flags, alu_clk} !== {8'h00, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_regs: got out=%h fl=%b clk=%b want 00/0000/0", alu_out, flags, alu_clk);
        end
    endtask

    task automatic test_add_cmp();
        exp_t        e;
        logic [7:0]  ins [5] = '{8'h01, 8'hA0, 8'h02, 8'h73, 8'hB0};
        logic [7:0]  xa  [5] = '{8'hFF, 8'hFF, 8'h7F, 8'h05, 8'h05};
        logic [7:0]  xb  [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h07};
        for (int i = 0; i < 5; i++) begin
            push_alu(ins[i], xa[i], xb[i], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({alu_out, flags, alu_clk} !== e) begin
                bad++;
                $display("FAIL add_cmp[%0d]: got out=%h fl=%b clk=%b want out=%h fl=%b clk=%b",
                         i, alu_out, flags, alu_clk, e.out, e.fl, e.pulse);
            end
        end
        // Final state after CMP 5-7 and a load: ADD result 80 held, flags from CMP {V0,N1,C1,Z0}
        total++;
        if ({alu_out, flags} !== {8'h80, 4'b0110}) begin
            bad++;
            $display("FAIL cmp_hold: got out=%h fl=%b want out=80 fl=0110", alu_out, flags);
        end
    endtask

    task automatic test_logic_shift();
        exp_t e;
        push_alu(8'h51, 8'h81, 8'h00, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if ({alu_out, flags, alu_clk} !== {8'h02, 4'b0010, 1'b1}) begin
            bad++;
            $display("FAIL shl1: got out=%h fl=%b clk=%b want 02/0010/1", alu_out, flags, alu_clk);
        end
        push_alu(8'h6F, 8'h81, 8'h00, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if ({alu_out, flags, alu_clk} !== {8'h00, 4'b0001, 1'b1}) begin
            bad++;
            $display("FAIL shr15: got out=%h fl=%b clk=%b want 00/0001/1", alu_out, flags, alu_clk);
        end
        for (int k = 0; k < 35; k++) begin
            logic [7:0] ins;
            if (k < 16)      ins = {4'h5, 4'(k)};
            else if (k < 32) ins = {4'h6, 4'(k - 16)};
            else             ins = {1'b0, 3'(k - 30), 4'h3};
            push_alu(ins, 8'hB5, 8'h3C, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({alu_out, flags, alu_clk} !== e) begin
                bad++;
                $display("FAIL shift_logic[%h]: got out=%h fl=%b clk=%b want out=%h fl=%b clk=%b",
                         ins, alu_out, flags, alu_clk, e.out, e.fl, e.pulse);
            end
        end
    endtask

    task automatic test_decode();
        exp_t       e;
        logic [7:0] d_ins [7] = '{8'h9A, 8'h8A, 8'hA7, 8'hB5, 8'hC3, 8'hD6, 8'h35};
        logic [7:0] d_exp [7] = '{8'b11000000, 8'b10000000, 8'b00100000, 8'b00010000,
                                  8'b00011000, 8'b00000100, 8'b00000000};
        for (int i = 0; i < 7; i++) begin
            logic [7:0] v;
            v = d_ins[i];
            push_alu(v, 8'h12, 8'h34, 1'b0);
            #1;
            total++;
            if ({nibble_read, nibble_hl, mva, fetch, we, mvb, jmp, jpl} !== d_exp[i]) begin
                bad++;
                $display("FAIL decode_strobes[%h]: got %b want %b", v,
                         {nibble_read, nibble_hl, mva, fetch, we, mvb, jmp, jpl}, d_exp[i]);
            end
            total++;
            if ({alu_op, alu_shamt, reg_sel, nibble_out, addr_offset, reg16_dst, reg16_src} !==
                {v[6:4], v[3:0], v[3:0], v[3:0], v[3:0], v[3:2], v[1:0]}) begin
                bad++;
                $display("FAIL decode_fields[%h]: got %h want %h", v,
                         {alu_op, alu_shamt, reg_sel, nibble_out, addr_offset, reg16_dst, reg16_src},
                         {v[6:4], v[3:0], v[3:0], v[3:0], v[3:0], v[3:2], v[1:0]});
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({alu_out, flags, alu_clk} !== e) begin
                bad++;
                $display("FAIL decode_regs[%h]: got out=%h fl=%b clk=%b want out=%h fl=%b clk=%b",
                         v, alu_out, flags, alu_clk, e.out, e.fl, e.pulse);
            end
        end
    endtask

    task automatic test_branch();
        exp_t       e;
        logic [7:0] setup [2] = '{8'h01, 8'h01};
        logic [7:0] sa    [2] = '{8'hFF, 8'h7F};
        for (int p = 0; p < 2; p++) begin
            push_alu(setup[p], sa[p], 8'h01, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            for (int k = 0; k < 33; k++) begin
                logic [7:0] ins;
                logic [2:0] want;
                if (k < 32) ins = {(k < 16) ? 4'hE : 4'hF, 4'(k)};
                else        ins = 8'hA1;
                want = {ins[7:4] == 4'hE, ins[7:4] == 4'hF,
                        (ins[7:5] == 3'b111) && exp_branch(ins[3:0], m_fl)};
                push_alu(ins, 8'h00, 8'h00, 1'b0);
                #1;
                total++;
                if ({jmp, jpl, branch} !== want) begin
                    bad++;
                    $display("FAIL branch[%h fl=%b]: got jmp/jpl/br=%b want %b", ins, m_fl, {jmp, jpl, branch}, want);
                end
                @(posedge clk); #1;
                e = sb.pop_front();
            end
        end
        // Spec vector: with Z=1 from FF+01, E1 branches while F2 and EF do not.
        push_alu(8'h01, 8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
        push_alu(8'hE1, 8'h00, 8'h00, 1'b0);
        #1;
        total++;
        if ({jmp, jpl, branch} !== 3'b101) begin
            bad++;
            $display("FAIL branch_z_e1: got %b want 101", {jmp, jpl, branch});
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        push_alu(8'hF2, 8'h00, 8'h00, 1'b0);
        #1;
        total++;
        if ({jmp, jpl, branch} !== 3'b010) begin
            bad++;
            $display("FAIL branch_z_f2: got %b want 010", {jmp, jpl, branch});
        end
        @(posedge clk); #1;
        e = sb.pop_front();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 40; k++) begin
            logic [6:0] r7;
            logic [7:0] ins;
            r7  = 7'($urandom);
            ins = {1'b0, r7};
            if (k % 8 == 0) ins = 8'h4F;
            push_alu(ins, 8'($urandom), 8'($urandom), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({alu_out, flags, alu_clk} !== e) begin
                bad++;
                $display("FAIL back_to_back[%0d %h]: got out=%h fl=%b clk=%b want out=%h fl=%b clk=%b",
                         k, ins, alu_out, flags, alu_clk, e.out, e.fl, e.pulse);
            end
        end
        // Same ADD held for two cycles pulses alu_clk on both cycles.
        for (int k = 0; k < 2; k++) begin
            push_alu(8'h05, 8'h10, 8'h20, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({alu_out, flags, alu_clk} !== {8'h30, 4'b0000, 1'b1}) begin
                bad++;
                $display("FAIL hold_add[%0d]: got out=%h fl=%b clk=%b want 30/0000/1", k, alu_out, flags, alu_clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [7:0] ins [4] = '{8'h0C, 8'h0C, 8'h7C, 8'hA0};
        logic       rr  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            push_alu(ins[i], 8'hC8, 8'h64, rr[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({alu_out, flags, alu_clk} !== e) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got out=%h fl=%b clk=%b want out=%h fl=%b clk=%b",
                         i, alu_out, flags, alu_clk, e.out, e.fl, e.pulse);
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_out = 8'h00;
        m_fl  = 4'h0;
        rst   = 1'b1;
        instr = 8'hE0;
        a     = 8'h00;
        b     = 8'h00;
        test_reset();
        test_add_cmp();
        test_logic_shift();
        test_decode();
        test_branch();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
